wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Consumer end of the MEM/WB pipeline register: the write-back stage of the 5-stage MIPS core.
//   Selects the write-back value (memory data vs ALU result).
//   Commits that value into the 32-entry general register file.
//   Serves the two ID-stage read ports (rs, rt).
//   Re-publishes the committed write for one cycle so the forwarding unit can observe it.
// PARAMETERS
//   DATA_W   32  register / data width
//   ADDR_W    5  register index width; register count = 2**ADDR_W
// PORTS
//   clk_WB            in   1       core clock, rising edge
//   rst_n_WB          in   1       asynchronous, active-low reset
//   data_WB_IN        in   DATA_W  memory read data from MEM/WB
//   resALU_WB_IN      in   DATA_W  ALU result from MEM/WB
//   mux2Output_WB_IN  in   ADDR_W  destination register index from MEM/WB
//   RegWrite_WB_IN    in   1       write enable from MEM/WB
//   MemtoReg_WB_IN    in   1       1 = write memory data, 0 = write ALU result
//   rs_addr_WB        in   ADDR_W  ID read port A index
//   rt_addr_WB        in   ADDR_W  ID read port B index
//   rs_data_WB        out  DATA_W  read port A data (combinational)
//   rt_data_WB        out  DATA_W  read port B data (combinational)
//   wbData_WB         out  DATA_W  registered copy of last committed value
//   wbAddr_WB         out  ADDR_W  registered copy of last committed index
//   wbValid_WB        out  1       1 for exactly the cycle after a commit
// BEHAVIOUR
// - Write-back value: wval = MemtoReg_WB_IN ? data_WB_IN : resALU_WB_IN (combinational).
// - Commit condition: commit = RegWrite_WB_IN && (mux2Output_WB_IN != 0).
// - Commit timing: on the rising clk_WB edge with commit, regs[mux2Output_WB_IN] <= wval.
//   Latency is 1 edge.
// - Register 0: hard-wired zero. Never written. Reads of index 0 always return 0.
// - Reset (rst_n_WB low, async): all registers = 0, wbData_WB = 0, wbAddr_WB = 0, wbValid_WB = 0.
//   Reset held low blocks all writes.
//   Reset asserted mid-cycle discards a pending write: the register stays 0.
// - Trace outputs: on each edge, wbValid_WB <= commit.
//   When commit is 1: wbData_WB <= wval, wbAddr_WB <= mux2Output_WB_IN.
//   When commit is 0: wbData_WB and wbAddr_WB hold their previous values.
// - RegWrite_WB_IN = 1 with index 0: no write, wbValid_WB <= 0.
// - Reads: rs_data_WB / rt_data_WB = regs[addr], subject to the bypass rule under CONFIGURATION.
// - Both read ports may address the same register; both return identical data.
// - No X propagation: MemtoReg_WB_IN is ignored when RegWrite_WB_IN = 0.
// - Consecutive writes to the same index: the last edge wins. No merging.
// CONFIGURATION
//   WB_REGFILE_BYPASS_EN
//     Defined:
//       - If commit and rs_addr_WB == mux2Output_WB_IN, rs_data_WB = wval in the same cycle.
//       - rt port behaves likewise.
//       - Write-before-read; removes the WB->ID hazard.
//     Undefined:
//       - Read ports return the pre-edge register contents.
//       - The hazard unit must stall one extra cycle.
//       - Index 0 returns 0 in both builds.
// TESTING
//   1. Reset: rst_n_WB=0 -> all outputs 0.
//      Release, read r1..r31 -> all 0.
//      wbValid_WB=0.
//   2. ALU write-back: RegWrite=1, MemtoReg=0, resALU=0x0000_00A5, dest=8, 1 edge -> read r8 = 0x0000_00A5.
//      Next cycle: wbValid_WB=1, wbAddr_WB=8.
//   3. Load write-back: RegWrite=1, MemtoReg=1, data=0xDEAD_BEEF, resALU=0x1234, dest=31 -> r31 = 0xDEAD_BEEF.
//      resALU is ignored.
//   4. Zero register: RegWrite=1, dest=0, resALU=0xFFFF_FFFF -> r0 reads 0, wbValid_WB=0.
//   5. Same-cycle read/write: r5 = 0x11, write 0x22 to r5 with rs_addr_WB=5 before the edge.
//      BYPASS_EN defined -> rs_data_WB = 0x22. Undefined -> 0x11.
//      After the edge both builds read 0x22.
//   6. Reset mid-operation: write 0x77 to r3 pending, assert rst_n_WB=0 before the edge -> r3 = 0.
//      After release, r3 stays 0 until written.

Source files
------------

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile -- write-back stage of the 5-stage MIPS core.
//
// Consumer end of the MEM/WB pipeline register. It picks the write-back value
// (load data or ALU result), commits it into the 2**ADDR_W entry register file
// and serves the two ID-stage read ports (rs, rt). It also re-publishes the
// committed write for one cycle, so the forwarding unit can observe it.
//
// Optional feature macro: WB_REGFILE_BYPASS_EN
//   defined   : a read port whose index matches the committing destination
//               returns the write-back value in the same cycle
//               (write-before-read, so there is no WB->ID hazard).
//   undefined : read ports return the pre-edge register contents, and the
//               hazard unit must stall one extra cycle.
//   Index 0 reads as zero in both builds.
//
// Ports
//   clk_WB            in   core clock, rising edge
//   rst_n_WB          in   asynchronous active-low reset
//   data_WB_IN        in   memory read data from MEM/WB
//   resALU_WB_IN      in   ALU result from MEM/WB
//   mux2Output_WB_IN  in   destination register index
//   RegWrite_WB_IN    in   write enable
//   MemtoReg_WB_IN    in   1 = memory data, 0 = ALU result
//   rs_addr_WB        in   read port A index
//   rt_addr_WB        in   read port B index
//   rs_data_WB        out  read port A data (combinational)
//   rt_data_WB        out  read port B data (combinational)
//   wbData_WB         out  registered copy of the last committed value
//   wbAddr_WB         out  registered copy of the last committed index
//   wbValid_WB        out  high for exactly the cycle after a commit
// -----------------------------------------------------------------------------

// One ID-stage read port. The top level instantiates it once per port.
module wb_regfile_rdport #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic [ADDR_W-1:0]            addr,
   input  logic [NREG-1:0][DATA_W-1:0]  regs,
   input  logic                         commit,
   input  logic [ADDR_W-1:0]            waddr,
   input  logic [DATA_W-1:0]            wval,
   output logic [DATA_W-1:0]            data
);
`ifdef WB_REGFILE_BYPASS_EN
   // Index 0 has priority over the bypass. A commit never targets r0, but
   // this ordering keeps the zero guarantee local to this port.
   always_comb begin
      data = regs[addr];
      if (addr == '0)
         data = '0;
      else if (commit && (addr == waddr))
         data = wval;
   end
`else
   // Without the bypass the write port is not observed here.
   logic unused_wr;
   assign unused_wr = ^{commit, waddr, wval};

   always_comb begin
      data = regs[addr];
      if (addr == '0)
         data = '0;
   end
`endif
endmodule

module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk_WB,
   input  logic              rst_n_WB,
   input  logic [DATA_W-1:0] data_WB_IN,
   input  logic [DATA_W-1:0] resALU_WB_IN,
   input  logic [ADDR_W-1:0] mux2Output_WB_IN,
   input  logic              RegWrite_WB_IN,
   input  logic              MemtoReg_WB_IN,
   input  logic [ADDR_W-1:0] rs_addr_WB,
   input  logic [ADDR_W-1:0] rt_addr_WB,
   output logic [DATA_W-1:0] rs_data_WB,
   output logic [DATA_W-1:0] rt_data_WB,
   output logic [DATA_W-1:0] wbData_WB,
   output logic [ADDR_W-1:0] wbAddr_WB,
   output logic              wbValid_WB
);
   localparam int NREG      = 1 << ADDR_W;
   localparam int NUM_PORTS = 2;   // rs, rt
   localparam int STAGES    = 1;   // trace valid delay

   // MEM/WB write request as a single bundle.
   typedef struct packed {
      logic              we;
      logic              mem2reg;
      logic [ADDR_W-1:0] dst;
      logic [DATA_W-1:0] mdata;
      logic [DATA_W-1:0] alu;
   } wb_req_t;

   wb_req_t                          req;
   logic [DATA_W-1:0]                wval;
   logic                             commit;
   logic [NREG-1:0][DATA_W-1:0]      regs;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
   logic [STAGES:0]                  vld_pipe;
   logic [STAGES:1]                  vld_q;

   assign req = '{we:      RegWrite_WB_IN,
                  mem2reg: MemtoReg_WB_IN,
                  dst:     mux2Output_WB_IN,
                  mdata:   data_WB_IN,
                  alu:     resALU_WB_IN};

   // A write to r0 is not a commit. That one rule keeps r0 at zero and also
   // suppresses the trace valid for it.
   assign commit = req.we && (req.dst != '0);
   // wval only matters when commit is set, so MemtoReg has no effect otherwise.
   assign wval   = req.mem2reg ? req.mdata : req.alu;

   // Register array. Entry 0 is reset and never written.
   always_ff @(posedge clk_WB or negedge rst_n_WB) begin
      if (!rst_n_WB)
         regs <= '0;
      else if (commit)
         regs[req.dst] <= wval;
   end

   // Trace outputs. Data and address hold when there is no commit.
   always_ff @(posedge clk_WB or negedge rst_n_WB) begin
      if (!rst_n_WB) begin
         wbData_WB <= '0;
         wbAddr_WB <= '0;
      end else if (commit) begin
         wbData_WB <= wval;
         wbAddr_WB <= req.dst;
      end
   end

   // Valid shift register: stage 0 is the live commit, and the last stage
   // is what the forwarding unit sees.
   assign vld_pipe = {vld_q, commit};

   always_ff @(posedge clk_WB or negedge rst_n_WB) begin
      if (!rst_n_WB)
         vld_q <= '0;
      else
         vld_q <= vld_pipe[STAGES-1:0];
   end

   assign wbValid_WB = vld_pipe[STAGES];

   // Read ports.
   assign rd_addr = {rt_addr_WB, rs_addr_WB};

   genvar p;
   generate
      for (p = 0; p < NUM_PORTS; p++) begin : g_rd
         wb_regfile_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NREG   (NREG)
         ) u_rd (
            .addr   (rd_addr[p]),
            .regs   (regs),
            .commit (commit),
            .waddr  (req.dst),
            .wval   (wval),
            .data   (rd_data[p])
         );
      end
   endgenerate

   assign rs_data_WB = rd_data[0];
   assign rt_data_WB = rd_data[1];
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
   logic        clk_WB;
   logic        rst_n_WB;
   logic [31:0] data_WB_IN;
   logic [31:0] resALU_WB_IN;
   logic [4:0]  mux2Output_WB_IN;
   logic        RegWrite_WB_IN;
   logic        MemtoReg_WB_IN;
   logic [4:0]  rs_addr_WB;
   logic [4:0]  rt_addr_WB;
   logic [31:0] rs_data_WB;
   logic [31:0] rt_data_WB;
   logic [31:0] wbData_WB;
   logic [4:0]  wbAddr_WB;
   logic        wbValid_WB;

   int errors = 0;
   int checks = 0;

   wb_regfile dut (
      .clk_WB           (clk_WB),
      .rst_n_WB         (rst_n_WB),
      .data_WB_IN       (data_WB_IN),
      .resALU_WB_IN     (resALU_WB_IN),
      .mux2Output_WB_IN (mux2Output_WB_IN),
      .RegWrite_WB_IN   (RegWrite_WB_IN),
      .MemtoReg_WB_IN   (MemtoReg_WB_IN),
      .rs_addr_WB       (rs_addr_WB),
      .rt_addr_WB       (rt_addr_WB),
      .rs_data_WB       (rs_data_WB),
      .rt_data_WB       (rt_data_WB),
      .wbData_WB        (wbData_WB),
      .wbAddr_WB        (wbAddr_WB),
      .wbValid_WB       (wbValid_WB)
   );

   initial begin
      clk_WB = 1'b0;
      forever #5 clk_WB = ~clk_WB;
   end

   // Drives one write on the next edge. The write request is removed 1 time
   // unit after that edge, so the caller can sample right after it returns.
   task automatic do_write(input logic [4:0] dst, input logic m2r,
                           input logic [31:0] mdata, input logic [31:0] alu);
      @(negedge clk_WB);
      RegWrite_WB_IN   = 1'b1;
      MemtoReg_WB_IN   = m2r;
      mux2Output_WB_IN = dst;
      data_WB_IN       = mdata;
      resALU_WB_IN     = alu;
      @(posedge clk_WB);
      #1;
      RegWrite_WB_IN   = 1'b0;
   endtask

   task automatic test_reset;
      rst_n_WB = 1'b0;
      RegWrite_WB_IN = 1'b0; MemtoReg_WB_IN = 1'b0; mux2Output_WB_IN = '0;
      data_WB_IN = '0; resALU_WB_IN = '0; rs_addr_WB = 5'd1; rt_addr_WB = 5'd31;
      #12;
      checks++; if (wbValid_WB !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", wbValid_WB); end
      checks++; if (wbData_WB !== 32'h0) begin errors++; $display("FAIL reset_wbdata got=%h exp=0", wbData_WB); end
      checks++; if (wbAddr_WB !== 5'd0) begin errors++; $display("FAIL reset_wbaddr got=%0d exp=0", wbAddr_WB); end
      checks++; if (rs_data_WB !== 32'h0 || rt_data_WB !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h/%h exp=0", rs_data_WB, rt_data_WB); end
      @(negedge clk_WB);
      rst_n_WB = 1'b1;
      for (int i = 1; i < 32; i++) begin
         rs_addr_WB = 5'(i);
         rt_addr_WB = 5'(i);
         #1;
         checks++; if (rs_data_WB !== 32'h0 || rt_data_WB !== 32'h0) begin errors++; $display("FAIL reset_r%0d got=%h/%h exp=0", i, rs_data_WB, rt_data_WB); end
      end
      @(posedge clk_WB); #1;
      checks++; if (wbValid_WB !== 1'b0) begin errors++; $display("FAIL reset_valid_after got=%0b exp=0", wbValid_WB); end
   endtask

   task automatic test_alu_wb;
      do_write(5'd8, 1'b0, 32'hCAFE_0000, 32'h0000_00A5);
      rs_addr_WB = 5'd8; #1;
      checks++; if (rs_data_WB !== 32'h0000_00A5) begin errors++; $display("FAIL alu_r8 got=%h exp=000000a5", rs_data_WB); end
      checks++; if (wbValid_WB !== 1'b1) begin errors++; $display("FAIL alu_valid got=%0b exp=1", wbValid_WB); end
      checks++; if (wbAddr_WB !== 5'd8) begin errors++; $display("FAIL alu_wbaddr got=%0d exp=8", wbAddr_WB); end
      checks++; if (wbData_WB !== 32'h0000_00A5) begin errors++; $display("FAIL alu_wbdata got=%h exp=000000a5", wbData_WB); end
      // The next edge has no write: valid drops, and data and address hold.
      @(posedge clk_WB); #1;
      checks++; if (wbValid_WB !== 1'b0) begin errors++; $display("FAIL alu_valid_drop got=%0b exp=0", wbValid_WB); end
      checks++; if (wbAddr_WB !== 5'd8 || wbData_WB !== 32'h0000_00A5) begin errors++; $display("FAIL alu_hold got=%0d/%h exp=8/000000a5", wbAddr_WB, wbData_WB); end
   endtask

   task automatic test_load_wb;
      do_write(5'd31, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
      rt_addr_WB = 5'd31; rs_addr_WB = 5'd31; #1;
      checks++; if (rt_data_WB !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_r31 got=%h exp=deadbeef", rt_data_WB); end
      checks++; if (rs_data_WB !== rt_data_WB) begin errors++; $display("FAIL load_same_port got=%h exp=%h", rs_data_WB, rt_data_WB); end
      checks++; if (wbData_WB !== 32'hDEAD_BEEF || wbAddr_WB !== 5'd31) begin errors++; $display("FAIL load_trace got=%h/%0d exp=deadbeef/31", wbData_WB, wbAddr_WB); end
      rs_addr_WB = 5'd8; #1;
      checks++; if (rs_data_WB !== 32'h0000_00A5) begin errors++; $display("FAIL load_r8_kept got=%h exp=000000a5", rs_data_WB); end
   endtask

   task automatic test_zero_reg;
      do_write(5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF);
      rs_addr_WB = 5'd0; rt_addr_WB = 5'd0; #1;
      checks++; if (rs_data_WB !== 32'h0 || rt_data_WB !== 32'h0) begin errors++; $display("FAIL zero_r0 got=%h/%h exp=0", rs_data_WB, rt_data_WB); end
      checks++; if (wbValid_WB !== 1'b0) begin errors++; $display("FAIL zero_valid got=%0b exp=0", wbValid_WB); end
      checks++; if (wbAddr_WB !== 5'd31 || wbData_WB !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_trace_hold got=%0d/%h exp=31/deadbeef", wbAddr_WB, wbData_WB); end
      // A write to r0 while r0 is being read must not be bypassed in either build.
      @(negedge clk_WB);
      RegWrite_WB_IN = 1'b1; mux2Output_WB_IN = 5'd0; MemtoReg_WB_IN = 1'b0; resALU_WB_IN = 32'h1234_5678;
      #1;
      checks++; if (rs_data_WB !== 32'h0) begin errors++; $display("FAIL zero_bypass got=%h exp=0", rs_data_WB); end
      RegWrite_WB_IN = 1'b0;
   endtask

   task automatic test_same_cycle;
      logic [31:0] exp_pre;
`ifdef WB_REGFILE_BYPASS_EN
      exp_pre = 32'h22;
`else
      exp_pre = 32'h11;
`endif
      do_write(5'd5, 1'b0, 32'h0, 32'h11);
      @(negedge clk_WB);
      RegWrite_WB_IN = 1'b1; MemtoReg_WB_IN = 1'b1; mux2Output_WB_IN = 5'd5;
      data_WB_IN = 32'h22; resALU_WB_IN = 32'h99;
      rs_addr_WB = 5'd5; rt_addr_WB = 5'd5; #1;
      checks++; if (rs_data_WB !== exp_pre) begin errors++; $display("FAIL same_rs_pre got=%h exp=%h", rs_data_WB, exp_pre); end
      checks++; if (rt_data_WB !== exp_pre) begin errors++; $display("FAIL same_rt_pre got=%h exp=%h", rt_data_WB, exp_pre); end
      // RegWrite low: no bypass in any build, and MemtoReg has no effect.
      RegWrite_WB_IN = 1'b0; #1;
      checks++; if (rs_data_WB !== 32'h11) begin errors++; $display("FAIL same_no_we got=%h exp=11", rs_data_WB); end
      RegWrite_WB_IN = 1'b1;
      @(posedge clk_WB); #1;
      RegWrite_WB_IN = 1'b0; #1;
      checks++; if (rs_data_WB !== 32'h22 || rt_data_WB !== 32'h22) begin errors++; $display("FAIL same_post got=%h/%h exp=22", rs_data_WB, rt_data_WB); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk_WB);
      RegWrite_WB_IN = 1'b1; MemtoReg_WB_IN = 1'b0; mux2Output_WB_IN = 5'd7; resALU_WB_IN = 32'h1;
      @(posedge clk_WB); #1;
      resALU_WB_IN = 32'h2;
      @(posedge clk_WB); #1;
      RegWrite_WB_IN = 1'b0;
      rs_addr_WB = 5'd7; #1;
      checks++; if (rs_data_WB !== 32'h2) begin errors++; $display("FAIL b2b_last_wins got=%h exp=2", rs_data_WB); end
      checks++; if (wbValid_WB !== 1'b1 || wbData_WB !== 32'h2 || wbAddr_WB !== 5'd7) begin errors++; $display("FAIL b2b_trace got=%0b/%h/%0d exp=1/2/7", wbValid_WB, wbData_WB, wbAddr_WB); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk_WB);
      RegWrite_WB_IN = 1'b1; MemtoReg_WB_IN = 1'b0; mux2Output_WB_IN = 5'd3; resALU_WB_IN = 32'h77;
      rs_addr_WB = 5'd3; rt_addr_WB = 5'd8;
      #2 rst_n_WB = 1'b0;
      #1;
      checks++; if (wbValid_WB !== 1'b0 || wbData_WB !== 32'h0 || wbAddr_WB !== 5'd0) begin errors++; $display("FAIL rstmid_trace got=%0b/%h/%0d exp=0/0/0", wbValid_WB, wbData_WB, wbAddr_WB); end
      @(posedge clk_WB); #1;
      checks++; if (rs_data_WB !== 32'h0) begin errors++; $display("FAIL rstmid_r3 got=%h exp=0", rs_data_WB); end
      checks++; if (rt_data_WB !== 32'h0) begin errors++; $display("FAIL rstmid_r8 got=%h exp=0", rt_data_WB); end
      @(negedge clk_WB);
      RegWrite_WB_IN = 1'b0;
      rst_n_WB = 1'b1;
      @(posedge clk_WB); #1;
      checks++; if (rs_data_WB !== 32'h0) begin errors++; $display("FAIL rstmid_r3_after got=%h exp=0", rs_data_WB); end
      do_write(5'd3, 1'b0, 32'h0, 32'h5A);
      #1;
      checks++; if (rs_data_WB !== 32'h5A) begin errors++; $display("FAIL rstmid_rewrite got=%h exp=0000005a", rs_data_WB); end
   endtask

   initial begin
      test_reset();
      test_alu_wb();
      test_load_wb();
      test_zero_reg();
      test_same_cycle();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
